// File: rtl/mem_port_arbiter_if.sv
// Command/response bundle between two requesters and the shared-array arbiter.
// A requester holds req with stable we/addr/wdata until its one-cycle gnt pulse appears.
interface mem_port_arbiter_if #(
   parameter int DW = 2,
   parameter int AW = 2
);
   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          gnt0;
   logic          gnt1;
   logic          rvalid0;
   logic          rvalid1;
   logic [DW-1:0] rdata;
   logic          busy;
   logic          state_dbg;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy, state_dbg
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, busy, state_dbg
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin scheduler for two requesters sharing one single-ported register array.
// Each command takes IDLE -> ACCESS -> IDLE; gnt and rvalid are registered one-cycle pulses.
module mem_port_arbiter #(
   parameter int DW = 2,
   parameter int AW = 2
) (
   input  logic               clock,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);
   localparam int DEPTH = 2 ** AW;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t        state_q;
   logic          last_q;
   logic          cmd_we_q;
   logic [AW-1:0] cmd_addr_q;
   logic [DW-1:0] cmd_wdata_q;
   logic          cmd_who_q;
   logic          gnt0_q;
   logic          gnt1_q;
   logic          rvalid0_q;
   logic          rvalid1_q;
   logic [DW-1:0] rdata_q;
   logic          busy_q;
   logic [DW-1:0] mem_q [DEPTH];

   logic          win1_d;
   logic          cmd_we_d;
   logic [AW-1:0] cmd_addr_d;
   logic [DW-1:0] cmd_wdata_d;

   // On a tie the requester that was not served last wins.
   always_comb begin
      win1_d      = bus.req1 & (~bus.req0 | ~last_q);
      cmd_we_d    = win1_d ? bus.we1    : bus.we0;
      cmd_addr_d  = win1_d ? bus.addr1  : bus.addr0;
      cmd_wdata_d = win1_d ? bus.wdata1 : bus.wdata0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         cmd_who_q   <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  cmd_we_q    <= cmd_we_d;
                  cmd_addr_q  <= cmd_addr_d;
                  cmd_wdata_q <= cmd_wdata_d;
                  cmd_who_q   <= win1_d;
                  last_q      <= win1_d;
                  gnt0_q      <= ~win1_d;
                  gnt1_q      <= win1_d;
                  busy_q      <= 1'b1;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               if (cmd_we_q) begin
                  mem_q[cmd_addr_q] <= cmd_wdata_q;
               end else begin
                  rdata_q   <= mem_q[cmd_addr_q];
                  rvalid0_q <= ~cmd_who_q;
                  rvalid1_q <= cmd_who_q;
               end
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt0      = gnt0_q;
   assign bus.gnt1      = gnt1_q;
   assign bus.rvalid0   = rvalid0_q;
   assign bus.rvalid1   = rvalid1_q;
   assign bus.rdata     = rdata_q;
   assign bus.busy      = busy_q;
   assign bus.state_dbg = (state_q == ACCESS);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single-port ops, ties, streaming alternation,
// reset during ACCESS and top-address boundary.
module tb_mem_port_arbiter;
   logic clock;
   logic reset;
   int   n_checks;
   int   n_fail;
   logic [1:0] exp_q [$];

   mem_port_arbiter_if bus ();

   mem_port_arbiter dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // clock/reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.req0   = 1'b0;
      bus.req1   = 1'b0;
      bus.we0    = 1'b0;
      bus.we1    = 1'b0;
      bus.addr0  = '0;
      bus.addr1  = '0;
      bus.wdata0 = '0;
      bus.wdata1 = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic drive(input int port, input logic we, input logic [1:0] addr, input logic [1:0] wd);
      if (port == 0) begin
         bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
      end else begin
         bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
      end
   endtask

   // Check rvalid/rdata for a read that finishes in this cycle, popping the scoreboard.
   task automatic check_read_done(input int port, input string tag);
      logic [1:0] exp;
      exp = exp_q.pop_front();
      chk({tag, "_rvalid0"}, 32'(bus.rvalid0), 32'(port == 0));
      chk({tag, "_rvalid1"}, 32'(bus.rvalid1), 32'(port == 1));
      chk({tag, "_rdata"},   32'(bus.rdata),   32'(exp));
   endtask

   // Called at a negedge in IDLE; returns at the negedge of N+2 with the FSM back in IDLE.
   task automatic op(input int port, input logic we, input logic [1:0] addr,
                     input logic [1:0] wd, input logic [1:0] exp_rd, input string tag);
      drive(port, we, addr, wd);
      if (!we) exp_q.push_back(exp_rd);
      @(posedge clock); @(negedge clock);
      chk({tag, "_gnt0"}, 32'(bus.gnt0), 32'(port == 0));
      chk({tag, "_gnt1"}, 32'(bus.gnt1), 32'(port == 1));
      chk({tag, "_busy1"}, 32'(bus.busy), 32'd1);
      idle_inputs();
      @(posedge clock); @(negedge clock);
      chk({tag, "_busy0"}, 32'(bus.busy), 32'd0);
      if (we) begin
         chk({tag, "_norv"}, 32'({bus.rvalid0, bus.rvalid1}), 32'd0);
      end else begin
         check_read_done(port, tag);
      end
   endtask

   initial begin
      logic [1:0] seen [1:8];
      n_checks = 0;
      n_fail   = 0;
      do_reset();

      // Reset state
      chk("rst_gnt",    32'({bus.gnt0, bus.gnt1}), 32'd0);
      chk("rst_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 32'd0);
      chk("rst_busy",   32'(bus.busy), 32'd0);
      chk("rst_rdata",  32'(bus.rdata), 32'd0);
      chk("rst_state",  32'(bus.state_dbg), 32'd0);
      for (int a = 0; a < 4; a++) begin
         op(a % 2, 1'b0, 2'(a), 2'b00, 2'b00, $sformatf("rst_rd%0d", a));
      end

      // Requester 0 write then read-back
      op(0, 1'b1, 2'd0, 2'b01, 2'b00, "wr0");
      op(0, 1'b0, 2'd0, 2'b00, 2'b01, "rd0");

      // Coincident requests after reset: write by 0 precedes read by 1
      do_reset();
      drive(0, 1'b1, 2'd3, 2'b11);
      drive(1, 1'b0, 2'd3, 2'b00);
      exp_q.push_back(2'b11);
      @(posedge clock); @(negedge clock);
      chk("tie_n1_gnt", 32'({bus.gnt0, bus.gnt1}), 32'b10);
      bus.req0 = 1'b0;
      @(posedge clock); @(negedge clock);
      chk("tie_n2_gnt", 32'({bus.gnt0, bus.gnt1}), 32'b00);
      chk("tie_n2_busy", 32'(bus.busy), 32'd0);
      @(posedge clock); @(negedge clock);
      chk("tie_n3_gnt", 32'({bus.gnt0, bus.gnt1}), 32'b01);
      bus.req1 = 1'b0;
      @(posedge clock); @(negedge clock);
      check_read_done(1, "tie_n4");

      // Both held high for 8 cycles: grants alternate 0,1,0,1 on odd cycles
      drive(0, 1'b0, 2'd1, 2'b00);
      drive(1, 1'b0, 2'd2, 2'b00);
      for (int c = 1; c <= 8; c++) begin
         @(posedge clock); @(negedge clock);
         seen[c] = {bus.gnt0, bus.gnt1};
         if (c == 8) idle_inputs();
      end
      chk("rr_c1", 32'(seen[1]), 32'b10);
      chk("rr_c2", 32'(seen[2]), 32'b00);
      chk("rr_c3", 32'(seen[3]), 32'b01);
      chk("rr_c4", 32'(seen[4]), 32'b00);
      chk("rr_c5", 32'(seen[5]), 32'b10);
      chk("rr_c6", 32'(seen[6]), 32'b00);
      chk("rr_c7", 32'(seen[7]), 32'b01);
      chk("rr_c8", 32'(seen[8]), 32'b00);
      @(posedge clock); @(negedge clock);

      // Reset during ACCESS of a write aborts it
      drive(0, 1'b1, 2'd2, 2'b10);
      @(posedge clock); @(negedge clock);
      chk("abort_gnt0", 32'(bus.gnt0), 32'd1);
      reset = 1'b1;
      idle_inputs();
      @(posedge clock); @(negedge clock);
      reset = 1'b0;
      chk("abort_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 32'd0);
      chk("abort_busy",   32'(bus.busy), 32'd0);
      chk("abort_state",  32'(bus.state_dbg), 32'd0);
      op(1, 1'b0, 2'd2, 2'b00, 2'b00, "abort_rd2");

      // Address boundary: distinct values in every entry, no aliasing
      op(0, 1'b1, 2'd0, 2'b10, 2'b00, "bw0");
      op(1, 1'b1, 2'd1, 2'b01, 2'b00, "bw1");
      op(0, 1'b1, 2'd2, 2'b00, 2'b00, "bw2");
      op(1, 1'b1, 2'd3, 2'b11, 2'b00, "bw3");
      op(0, 1'b0, 2'd3, 2'b00, 2'b11, "br3");
      op(1, 1'b0, 2'd0, 2'b00, 2'b10, "br0");
      op(0, 1'b0, 2'd1, 2'b00, 2'b01, "br1");
      chk("rdata_hold", 32'(bus.rdata), 32'b01);
      @(posedge clock); @(negedge clock);
      chk("rdata_hold2", 32'(bus.rdata), 32'b01);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester round-robin scheduler owning a small single-ported register array (default 4 × 2-bit). It serialises read and write commands from two independent requesters onto the one array port and returns read data with a per-requester valid strobe. It sits between the control processes that produce coincident enable pulses and the shared storage those processes would otherwise access concurrently.

## Interface
- DW, 2, data width of each array entry
- AW, 2, address width; the array depth is 2**AW (4 by default)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request from requester 0 / 1; hold high until the matching gnt is seen
- we0 / we1  in  1  1 = write, 0 = read; must be stable while req is high
- addr0 / addr1  in  AW  entry address; must be stable while req is high
- wdata0 / wdata1  in  DW  write data; must be stable while req is high
- gnt0 / gnt1  out  1  one-cycle grant pulse; the command was captured at the preceding edge
- rvalid0 / rvalid1  out  1  one-cycle pulse; rdata is valid for that requester's read
- rdata  out  DW  read data; holds its value between reads
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- Storage: mem[0 .. 2**AW-1], DW bits per entry, used only by this block.
- FSM states are IDLE and ACCESS.
- IDLE, one or more req high:
  - pick the winner (see arbitration below);
  - latch the winner's we, addr and wdata into a command register;
  - set the winner's gnt for the next cycle;
  - update `last` to the winner;
  - go to ACCESS.
- IDLE, no req: stay in IDLE; all pulse outputs are 0.
- ACCESS:
  - write: mem[addr] <= wdata;
  - read: rdata <= mem[addr], and the winner's rvalid is set for the next cycle;
  - always return to IDLE.
- Arbitration: round-robin on the `last` pointer.
  - When only one req is high, that requester wins.
  - When both are high, the requester that is not `last` wins.
  - `last` resets to 1, so requester 0 wins the first tie.
- Requester rule: drop req at the edge that ends the gnt cycle. If req is still high when the FSM is back in IDLE, it is treated as a new request.
- Address arithmetic: there is no wrap or offset logic. An addr of all-ones selects the last entry. Every AW-bit value is a legal address.
- Read after write to the same address: the read returns the new data, because the write completes in ACCESS before any later grant.
- Reset, synchronous:
  - state is IDLE and `last` is 1;
  - gnt0, gnt1, rvalid0, rvalid1 and busy are 0;
  - rdata is 0 and every mem entry is 0.
  - Reset in ACCESS aborts the pending operation: a write is not performed and no rvalid is issued.
  - Reset has priority over every other event.

## Timing
- Let N be the cycle in which the FSM is in IDLE and samples a request.
- N+1: gnt of the winner is high, busy is high, the state is ACCESS.
- N+2: for a write, mem is updated (visible to a read issued in this cycle). For a read, rdata is valid and the winner's rvalid is high. The state is IDLE and busy is low.
- Read latency is 2 cycles from the request sample to rvalid.
- Maximum throughput is one operation per 2 cycles.
- Two requesters holding req continuously get alternating grants every 2 cycles: 0, 1, 0, 1, ...
- gnt and rvalid are registered outputs.
- At most one of gnt0/gnt1 is high in any cycle; the same holds for rvalid0/rvalid1.
- A requester that loses a tie keeps req high. It is served at the next IDLE sample, so the wait is at most 2 cycles.

## Test plan
- Reset → after reset is released: all outputs 0, busy 0; reads of addresses 0–3 return 0 with rvalid on the correct port.
- Requester 0 writes 2'b01 to addr 0 (gnt0 at N+1), then reads addr 0 → rvalid0 at read-N+2 with rdata = 2'b01; gnt1 and rvalid1 are never high.
- Both requesters raise req in the same cycle after reset, req0 writes addr 3 = 2'b11 and req1 reads addr 3 → gnt0 comes first, then gnt1 two cycles later; rvalid1 returns rdata = 2'b11.
- req0 and req1 held high continuously for 8 cycles, all reads → grants alternate gnt0, gnt1, gnt0, gnt1 on cycles N+1, N+3, N+5, N+7.
- Reset asserted during ACCESS of a write of 2'b10 to addr 2 → no rvalid, FSM returns to IDLE; a later read of addr 2 returns 2'b00.
- Address boundary: writes of distinct values to addr 0–3, then reads of 3 and 0 → each read returns its own value; no aliasing at the top address.
